// File: rtl/ldtu_gain_win_ctrl_pkg.sv
`default_nettype none
// ============================================================================
// Module      : ldtu_gain_win_ctrl_pkg
// Description : Shared LiTe-DTU constants for the gain-window controller:
//               FIFO pointer geometry, reference-sample offsets, window
//               lengths and GAIN_SEL_MODE encodings.
// Ports       : none (package)
// Revision    : 1.0 - initial release
// ============================================================================
package ldtu_gain_win_ctrl_pkg;

    // FIFO geometry: depth 8. The read pointer leads the write pointers by two slots.
    localparam int         C_PTR_W       = 3;
    localparam logic [2:0] C_RD_PTR_INIT = 3'b010;

    // Offset from the read pointer to the x10 reference sample
    localparam int C_REF_OFF_8  = 3;
    localparam int C_REF_OFF_16 = 5;

    // Window lengths in samples and the width of the window counter
    localparam int C_WIN_LEN_8  = 8;
    localparam int C_WIN_LEN_16 = 16;
    localparam int C_WCNT_W     = 4;

    // Default width of the saturation-event counter
    localparam int C_CNT_W = 16;

    typedef enum logic [1:0] {
        MODE_WIN8      = 2'b00,
        MODE_WIN16     = 2'b01,
        MODE_FORCE_G10 = 2'b10,
        MODE_FORCE_G1  = 2'b11
    } gain_mode_e;

    // The counter is loaded with W-1 so that it runs for W cycles before reaching 0
    function automatic logic [C_WCNT_W-1:0] win_reload(input logic [1:0] mode);
        return (mode == MODE_WIN16) ? C_WCNT_W'(C_WIN_LEN_16 - 1)
                                    : C_WCNT_W'(C_WIN_LEN_8 - 1);
    endfunction

endpackage
`default_nettype wire

// File: rtl/ldtu_gain_win_ctrl_if.sv
`default_nettype none
// ============================================================================
// Module      : ldtu_gain_win_ctrl_if
// Description : Control/status bundle of the gain-window controller.
// Ports       : GAIN_SEL_MODE, sat_flag, clr_cnt   (master -> slave)
//               rd_ptr, ref_ptr, sel_g1, sat_events (slave -> master)
// Revision    : 1.0 - initial release
// ============================================================================
interface ldtu_gain_win_ctrl_if
    import ldtu_gain_win_ctrl_pkg::*;
#(
    parameter int PTR_W = C_PTR_W,
    parameter int CNT_W = C_CNT_W
) ();

    logic [1:0]       GAIN_SEL_MODE;
    logic             sat_flag;
    logic             clr_cnt;
    logic [PTR_W-1:0] rd_ptr;
    logic [PTR_W-1:0] ref_ptr;
    logic             sel_g1;
    logic [CNT_W-1:0] sat_events;

    modport master (
        output GAIN_SEL_MODE, sat_flag, clr_cnt,
        input  rd_ptr, ref_ptr, sel_g1, sat_events
    );

    modport slave (
        input  GAIN_SEL_MODE, sat_flag, clr_cnt,
        output rd_ptr, ref_ptr, sel_g1, sat_events
    );

endinterface
`default_nettype wire

// File: rtl/ldtu_sat_evt_cnt.sv
`default_nettype none
// ============================================================================
// Module      : ldtu_sat_evt_cnt
// Description : Saturating event counter with a synchronous clear. When a
//               clear and an increment arrive together, the count restarts
//               at 1 so that the coincident event is not lost.
// Ports       : clk, rst_n (async active-low), clr, inc, cnt[CNT_W-1:0]
// Revision    : 1.0 - initial release
// ============================================================================
module ldtu_sat_evt_cnt #(
    parameter int CNT_W = 16
) (
    input  wire logic             clk,
    input  wire logic             rst_n,
    input  wire logic             clr,
    input  wire logic             inc,
    output logic      [CNT_W-1:0] cnt
);

    logic [CNT_W-1:0] r_cnt;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_cnt <= '0;
        end else if (clr) begin
            r_cnt <= inc ? CNT_W'(1) : '0;
        end else if (inc && (r_cnt != '1)) begin
            r_cnt <= r_cnt + CNT_W'(1);
        end
    end

    assign cnt = r_cnt;

endmodule
`default_nettype wire

// File: rtl/ldtu_gain_win_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : ldtu_gain_win_ctrl
// Description : LiTe-DTU gain-selection window controller. Generates the
//               free-running FIFO read pointer and the x10 reference pointer.
//               It opens a gain-x1 window of 8 or 16 samples on saturation,
//               and retriggers the window while saturation persists. Two
//               modes force the gain to x10 or to x1. Window openings are
//               counted.
// Ports       : CLK_          clock, rising edge
//               reset_        async active-low reset
//               bus (slave)   GAIN_SEL_MODE, sat_flag, clr_cnt in;
//                             rd_ptr, ref_ptr, sel_g1, sat_events out
// Revision    : 1.0 - initial release
// ============================================================================
module ldtu_gain_win_ctrl
    import ldtu_gain_win_ctrl_pkg::*;
#(
    parameter int               PTR_W       = C_PTR_W,
    parameter logic [PTR_W-1:0] RD_PTR_INIT = PTR_W'(C_RD_PTR_INIT),
    parameter int               REF_OFF_8   = C_REF_OFF_8,
    parameter int               REF_OFF_16  = C_REF_OFF_16,
    parameter int               CNT_W       = C_CNT_W
) (
    input  wire logic         CLK_,
    input  wire logic         reset_,
    ldtu_gain_win_ctrl_if.slave bus
);

    typedef enum logic [1:0] {
        ST_G10       = 2'b00,
        ST_WIN       = 2'b01,
        ST_FORCE_G10 = 2'b10,
        ST_FORCE_G1  = 2'b11
    } state_e;

    state_e              r_state;
    state_e              w_state_nxt;
    logic [1:0]          r_mode_q;
    logic [1:0]          r_mode_prev;
    logic [PTR_W-1:0]    r_rd_ptr;
    logic [PTR_W-1:0]    w_ref_off;
    logic [C_WCNT_W-1:0] r_wcnt;
    logic [C_WCNT_W-1:0] w_wcnt_nxt;
    logic                w_mode_chg;
    logic                w_open;

    // The mode is registered once (r_mode_q), and all decisions use that copy.
    // r_mode_prev holds the copy from the cycle before, so that a mode change
    // can be detected and the current window aborted.
    always_ff @(posedge CLK_ or negedge reset_) begin
        if (!reset_) begin
            r_mode_q    <= MODE_WIN8;
            r_mode_prev <= MODE_WIN8;
            r_rd_ptr    <= RD_PTR_INIT;
            r_state     <= ST_G10;
            r_wcnt      <= '0;
        end else begin
            r_mode_q    <= bus.GAIN_SEL_MODE;
            r_mode_prev <= r_mode_q;
            r_rd_ptr    <= r_rd_ptr + PTR_W'(1);
            r_state     <= w_state_nxt;
            r_wcnt      <= w_wcnt_nxt;
        end
    end

    assign w_mode_chg = (r_mode_q != r_mode_prev);

    always_comb begin
        w_state_nxt = r_state;
        w_wcnt_nxt  = r_wcnt;
        w_open      = 1'b0;
        if (w_mode_chg) begin
            // A mode change takes priority. sat_flag is ignored in this cycle.
            w_wcnt_nxt = '0;
            case (r_mode_q)
                MODE_FORCE_G10: w_state_nxt = ST_FORCE_G10;
                MODE_FORCE_G1:  w_state_nxt = ST_FORCE_G1;
                default:        w_state_nxt = ST_G10;
            endcase
        end else begin
            case (r_state)
                ST_G10: begin
                    if (!r_mode_q[1] && bus.sat_flag) begin
                        w_state_nxt = ST_WIN;
                        w_wcnt_nxt  = win_reload(r_mode_q);
                        w_open      = 1'b1;
                    end
                end
                ST_WIN: begin
                    if (bus.sat_flag) begin
                        w_wcnt_nxt = win_reload(r_mode_q);
                    end else if (r_wcnt == '0) begin
                        w_state_nxt = ST_G10;
                    end else begin
                        w_wcnt_nxt = r_wcnt - C_WCNT_W'(1);
                    end
                end
                default: begin
                    // Forced states ignore sat_flag and hold until the mode changes
                end
            endcase
        end
    end

    assign w_ref_off    = (r_mode_q == MODE_WIN16) ? PTR_W'(REF_OFF_16) : PTR_W'(REF_OFF_8);
    assign bus.rd_ptr   = r_rd_ptr;
    assign bus.ref_ptr  = r_rd_ptr + w_ref_off;
    assign bus.sel_g1   = (r_state == ST_WIN) || (r_state == ST_FORCE_G1);

    ldtu_sat_evt_cnt #(
        .CNT_W (CNT_W)
    ) u_sat_evt_cnt (
        .clk   (CLK_),
        .rst_n (reset_),
        .clr   (bus.clr_cnt),
        .inc   (w_open),
        .cnt   (bus.sat_events)
    );

endmodule
`default_nettype wire

// File: tb/tb_ldtu_gain_win_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : tb_ldtu_gain_win_ctrl
// Description : Self-checking bench for ldtu_gain_win_ctrl. Two instances
//               receive the same stimulus. One uses the default 16-bit event
//               counter. The other uses a 4-bit counter, so that saturation
//               is reached in few openings. A window-remaining model is
//               checked against both instances every cycle, and directed
//               literal checks pin the model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_ldtu_gain_win_ctrl;
    import ldtu_gain_win_ctrl_pkg::*;

    logic       CLK_   = 1'b0;
    logic       reset_ = 1'b1;
    logic [1:0] mode_drv = 2'b00;
    logic       sat_drv  = 1'b0;
    logic       clr_drv  = 1'b0;

    always #5 CLK_ = ~CLK_;

    ldtu_gain_win_ctrl_if #(.PTR_W(3), .CNT_W(16)) bus   ();
    ldtu_gain_win_ctrl_if #(.PTR_W(3), .CNT_W(4))  bus_s ();

    assign bus.GAIN_SEL_MODE   = mode_drv;
    assign bus.sat_flag        = sat_drv;
    assign bus.clr_cnt         = clr_drv;
    assign bus_s.GAIN_SEL_MODE = mode_drv;
    assign bus_s.sat_flag      = sat_drv;
    assign bus_s.clr_cnt       = clr_drv;

    ldtu_gain_win_ctrl #(.CNT_W(16)) dut (
        .CLK_   (CLK_),
        .reset_ (reset_),
        .bus    (bus.slave)
    );

    ldtu_gain_win_ctrl #(.CNT_W(4)) dut_s (
        .CLK_   (CLK_),
        .reset_ (reset_),
        .bus    (bus_s.slave)
    );

    int n_checks = 0;
    int n_errors = 0;

    task automatic chk(input string nm, input int act, input int exp);
        n_checks++;
        if (act != exp) begin
            n_errors++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", nm, act, exp, $time);
        end
    endtask

    // ------------------------------------------------------------------
    // Model. m_win is the number of cycles for which gain x1 is still
    // owed (W after a saturated sample). m_ev is an unbounded count of
    // openings; each counter width clips it to its own maximum value.
    // ------------------------------------------------------------------
    int         m_rd        = 2;
    logic [1:0] m_mode_q    = 2'b00;
    logic [1:0] m_mode_prev = 2'b00;
    int         m_win       = 0;
    bit         m_sel       = 1'b0;
    int         m_ev        = 0;

    always @(posedge CLK_ or negedge reset_) begin
        if (!reset_) begin
            m_rd = 2; m_mode_q = 2'b00; m_mode_prev = 2'b00;
            m_win = 0; m_sel = 1'b0; m_ev = 0;
        end else begin
            bit opened;
            opened = 1'b0;
            if (m_mode_q != m_mode_prev) begin
                m_win = 0;
                m_sel = (m_mode_q == 2'b11);
            end else if (m_mode_q[1] == 1'b0) begin
                if (sat_drv) begin
                    opened = (m_win == 0);
                    m_win  = (m_mode_q == 2'b01) ? 16 : 8;
                end else if (m_win > 0) begin
                    m_win--;
                end
                m_sel = (m_win > 0);
            end
            if (clr_drv)     m_ev = opened ? 1 : 0;
            else if (opened) m_ev++;
            m_rd        = (m_rd + 1) % 8;
            m_mode_prev = m_mode_q;
            m_mode_q    = mode_drv;
        end
    end

    bit cmp_en = 1'b0;

    always @(negedge CLK_) begin
        if (cmp_en) begin
            int exp_ref;
            exp_ref = (m_rd + ((m_mode_q == 2'b01) ? 5 : 3)) % 8;
            chk("model rd_ptr",       int'(bus.rd_ptr),       m_rd);
            chk("model ref_ptr",      int'(bus.ref_ptr),      exp_ref);
            chk("model sel_g1",       int'(bus.sel_g1),       int'(m_sel));
            chk("model sat_events",   int'(bus.sat_events),   (m_ev > 65535) ? 65535 : m_ev);
            chk("model s rd_ptr",     int'(bus_s.rd_ptr),     m_rd);
            chk("model s sel_g1",     int'(bus_s.sel_g1),     int'(m_sel));
            chk("model s sat_events", int'(bus_s.sat_events), (m_ev > 15) ? 15 : m_ev);
        end
    end

    task automatic tick(input int n);
        repeat (n) @(posedge CLK_);
        #1;
    endtask

    int exp_rd [9] = '{3, 4, 5, 6, 7, 0, 1, 2, 3};
    int exp_ref[9] = '{6, 7, 0, 1, 2, 3, 4, 5, 6};

    initial begin
        #1 reset_ = 1'b0;
        #1 cmp_en = 1'b1;
        tick(3);
        chk("reset rd_ptr",     int'(bus.rd_ptr),     2);
        chk("reset ref_ptr",    int'(bus.ref_ptr),    5);
        chk("reset sel_g1",     int'(bus.sel_g1),     0);
        chk("reset sat_events", int'(bus.sat_events), 0);

        // Pointers start counting on the first edge after release
        reset_ = 1'b1;
        #1 chk("release rd_ptr", int'(bus.rd_ptr), 2);
        for (int i = 0; i < 9; i++) begin
            tick(1);
            chk("seq rd_ptr",  int'(bus.rd_ptr),  exp_rd[i]);
            chk("seq ref_ptr", int'(bus.ref_ptr), exp_ref[i]);
        end

        // Mode 00: a single pulse in cycle 10 gives sel_g1 in cycles 11..18
        clr_drv = 1'b1; tick(1); clr_drv = 1'b0; tick(2);
        sat_drv = 1'b1; tick(1); sat_drv = 1'b0;
        for (int c = 11; c <= 18; c++) begin
            chk("w8 sel_g1 high", int'(bus.sel_g1), 1);
            tick(1);
        end
        chk("w8 sel_g1 low at 19", int'(bus.sel_g1), 0);
        chk("w8 sat_events", int'(bus.sat_events), 1);

        // Mode 01: pulses in cycles 10 and 20 give sel_g1 in cycles 11..36
        mode_drv = 2'b01; tick(3);
        clr_drv = 1'b1; tick(1); clr_drv = 1'b0;
        sat_drv = 1'b1; tick(1); sat_drv = 1'b0;
        for (int c = 11; c <= 36; c++) begin
            chk("w16 sel_g1 high", int'(bus.sel_g1), 1);
            sat_drv = (c == 20);
            tick(1);
        end
        sat_drv = 1'b0;
        chk("w16 sel_g1 low at 37", int'(bus.sel_g1), 0);
        chk("w16 sat_events", int'(bus.sat_events), 1);

        // Forced x1: takes effect two cycles after the write, and sat_flag is ignored
        mode_drv = 2'b11; tick(1);
        chk("fg1 sel_g1 +1", int'(bus.sel_g1), 0);
        tick(1);
        chk("fg1 sel_g1 +2", int'(bus.sel_g1), 1);
        sat_drv = 1'b1; tick(3);
        chk("fg1 sel_g1 sat", int'(bus.sel_g1), 1);
        chk("fg1 sat_events", int'(bus.sat_events), 1);
        // Forced x10 while sat_flag stays high
        mode_drv = 2'b10; tick(1);
        chk("fg10 sel_g1 +1", int'(bus.sel_g1), 1);
        tick(1);
        chk("fg10 sel_g1 +2", int'(bus.sel_g1), 0);
        tick(5);
        chk("fg10 sel_g1 sat held", int'(bus.sel_g1), 0);
        chk("fg10 sat_events", int'(bus.sat_events), 1);
        sat_drv = 1'b0;

        // Mode change 00->01 in window cycle 4 aborts the window
        mode_drv = 2'b00; tick(3);
        sat_drv = 1'b1; tick(1); sat_drv = 1'b0;
        tick(3);
        chk("abort sel_g1 win cyc 4", int'(bus.sel_g1), 1);
        mode_drv = 2'b01; tick(1);
        chk("abort sel_g1 +1", int'(bus.sel_g1), 1);
        tick(1);
        chk("abort sel_g1 +2", int'(bus.sel_g1), 0);
        tick(10);
        chk("abort sel_g1 stays", int'(bus.sel_g1), 0);

        // Reset asserted mid-window
        mode_drv = 2'b00; tick(3);
        sat_drv = 1'b1; tick(1); sat_drv = 1'b0; tick(2);
        chk("rst pre sel_g1", int'(bus.sel_g1), 1);
        reset_ = 1'b0;
        #1;
        chk("rst async sel_g1",     int'(bus.sel_g1),     0);
        chk("rst async rd_ptr",     int'(bus.rd_ptr),     2);
        chk("rst async sat_events", int'(bus.sat_events), 0);
        tick(2);
        reset_ = 1'b1; tick(1);
        chk("rst after rd_ptr", int'(bus.rd_ptr), 3);
        chk("rst after sel_g1", int'(bus.sel_g1), 0);

        // Twenty openings: the wide counter reads 20, the 4-bit counter saturates at 15
        tick(2);
        repeat (20) begin
            sat_drv = 1'b1; tick(1); sat_drv = 1'b0; tick(9);
        end
        chk("cnt wide 20",      int'(bus.sat_events),   20);
        chk("cnt narrow sat15", int'(bus_s.sat_events), 15);
        // A clear that coincides with an opening restarts the count at 1
        sat_drv = 1'b1; clr_drv = 1'b1; tick(1); sat_drv = 1'b0; clr_drv = 1'b0;
        chk("clr+open wide",   int'(bus.sat_events),   1);
        chk("clr+open narrow", int'(bus_s.sat_events), 1);
        tick(9);
        clr_drv = 1'b1; tick(1); clr_drv = 1'b0;
        chk("clr alone", int'(bus.sat_events), 0);
        // A clear that coincides with a retrigger (not an opening) gives 0
        sat_drv = 1'b1; tick(1); sat_drv = 1'b0; tick(2);
        sat_drv = 1'b1; clr_drv = 1'b1; tick(1); sat_drv = 1'b0; clr_drv = 1'b0;
        chk("clr+retrigger", int'(bus.sat_events), 0);
        tick(12);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/ldtu_gain_win_ctrl.md
LDTU_GAIN_WIN_CTRL -- requirements
Module: ldtu_gain_win_ctrl

Interface
Parameters:
REQ-001 SHALL have parameter PTR_W, default 3, FIFO read/ref pointer width (FIFO depth 8).
REQ-002 SHALL have parameter RD_PTR_INIT, default 3'b010, read pointer value after reset (two-slot lead over write pointers).
REQ-003 SHALL have parameter REF_OFF_8, default 3, reference-sample offset in 8-sample window mode.
REQ-004 SHALL have parameter REF_OFF_16, default 5, reference-sample offset in 16-sample window mode.
REQ-005 SHALL have parameter CNT_W, default 16, saturation-event counter width.

Ports (one clock; reset asynchronous, active-low):
REQ-006 SHALL have CLK_  input  1  LiTe-DTU clock, all state on rising edge.
REQ-007 SHALL have reset_  input  1  asynchronous active-low reset (0 = inactive DTU, 1 = active).
REQ-008 SHALL have GAIN_SEL_MODE  input  2  00 window 8, 01 window 16, 10 force gain x10, 11 force gain x1.
REQ-009 SHALL have sat_flag  input  1  gain-x10 reference sample >= saturation threshold; valid each cycle.
REQ-010 SHALL have clr_cnt  input  1  single-cycle pulse, clears sat_events.
REQ-011 SHALL have rd_ptr  output  PTR_W  FIFO read pointer for both gain FIFOs.
REQ-012 SHALL have ref_ptr  output  PTR_W  FIFO x10 reference-sample pointer.
REQ-013 SHALL have sel_g1  output  1  1 = transmit gain-x1 sample, 0 = gain-x10 sample.
REQ-014 SHALL have sat_events  output  CNT_W  number of window openings since reset/clear.

Function
REQ-015 SHALL register GAIN_SEL_MODE into mode_q every cycle; all decisions use mode_q (one-cycle mode latency).
REQ-016 SHALL increment rd_ptr by 1 each cycle, modulo 2^PTR_W (7 -> 0 wrap).
REQ-017 SHALL drive ref_ptr combinationally = rd_ptr + REF_OFF_16 when mode_q==01, else rd_ptr + REF_OFF_8, modulo 2^PTR_W.
REQ-018 SHALL implement FSM states G10, WIN, FORCE_G10, FORCE_G1; sel_g1 = 1 in WIN and FORCE_G1, else 0, decoded from registered state.
REQ-019 SHALL, in G10 with mode_q in {00,01}, go to WIN on sat_flag=1 and load window counter with W-1 (W=8 for 00, W=16 for 01).
REQ-020 SHALL, in WIN, reload counter to W-1 on sat_flag=1 (retrigger); else decrement; leave to G10 when counter==0 and sat_flag=0.
REQ-021 SHALL therefore hold sel_g1=1 for exactly W cycles after the last cycle in which sat_flag was sampled high, starting the cycle after the first sample.
REQ-022 SHALL, on any mode_q change, abort current window: mode_q 10 -> FORCE_G10, 11 -> FORCE_G1, 00/01 -> G10 with counter cleared; sat_flag ignored that cycle.
REQ-023 SHALL ignore sat_flag in FORCE_G10 and FORCE_G1.
REQ-024 SHALL increment sat_events on each G10->WIN transition only (retriggers not counted), saturating at all-ones.
REQ-025 SHALL, on clr_cnt=1 with simultaneous G10->WIN transition, set sat_events to 1; with no transition, to 0.
REQ-026 SHALL use a 4-bit window counter; upper bit unused in mode 00.

Reset
REQ-027 SHALL, while reset_=0, asynchronously force rd_ptr=RD_PTR_INIT, state=G10, counter=0, mode_q=00, sel_g1=0, sat_events=0.
REQ-028 SHALL, on reset_ assertion mid-window, drop sel_g1 to 0 immediately without completing the window.
REQ-029 SHALL begin pointer increment on the first rising CLK_ edge with reset_=1.

Structure
REQ-030 SHALL take PTR_W, RD_PTR_INIT, REF_OFF_8/16, window lengths and mode encodings from the shared LiTe-DTU constants package.
REQ-031 SHALL keep FSM state encoding local to the module.
REQ-032 SHALL instantiate one sub-module, ldtu_sat_evt_cnt (saturating clearable counter).

Verification
REQ-033 SHALL verify reset: reset_=0 mid-window -> sel_g1=0, rd_ptr=2, sat_events=0 same cycle; after release rd_ptr 2,3..7,0,1 with ref_ptr 5,6,7,0.. (mode 00).
REQ-034 SHALL verify mode 00: single sat_flag pulse at cycle 10 -> sel_g1=1 cycles 11-18, 0 at 19; sat_events=1.
REQ-035 SHALL verify mode 01 retrigger: sat pulses at 10 and 20 -> sel_g1=1 cycles 11-36; sat_events=1; ref_ptr=rd_ptr+5.
REQ-036 SHALL verify forced modes: mode 11 -> sel_g1=1 two cycles after mode write, sat_flag ignored; mode 10 -> sel_g1=0 despite sat_flag=1 held.
REQ-037 SHALL verify mode change mid-window: mode 00->01 at window cycle 4 -> state G10, sel_g1=0 two cycles after write.
REQ-038 SHALL verify counter: force 65535 openings -> sat_events=0xFFFF held; clr_cnt coincident with opening -> 1.
